lifo_stack_param: RTL and testbench

//  Parametrised hardware LIFO stack serving the pipeline's PUSH/POP path in the MEM stage.

---
 rtl/lifo_stack_param_pkg.sv | 39 +++
 rtl/lifo_stack_param_regfile.sv | 36 +++
 rtl/lifo_stack_param.sv | 165 ++++++++++++++++
 tb/tb_lifo_stack_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_param_pkg.sv
// Package: lifo_stack_param_pkg
// Purpose : Shared definitions for the parametrised LIFO stack.
//           - Default data width and depth.
//           - A constant ceil(log2) helper used to size the stack pointer
//             and the storage address.
//           - The operation encoding that the top-level priority decode
//             resolves to on each clock edge.
// Ports   : none (package)
package lifo_stack_param_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 64;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int stackClog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // One operation is selected per edge, in strict priority order.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,        // push+pop on a non-empty stack: overwrite top
    OP_PUSH_ON_EMPTY,  // push+pop on an empty stack: push, flag underflow
    OP_PUSH,
    OP_OVERFLOW,       // push while full: write suppressed
    OP_POP,
    OP_UNDERFLOW       // pop while empty: nothing moves
  } stackOp_e;

endpackage

// File: rtl/lifo_stack_param_regfile.sv
// Module : lifo_stack_param_regfile
// Purpose: DEPTH x DATA_W storage for the stack. One synchronous write
//          port and one asynchronous read port, so the top-of-stack word
//          is available in the same cycle the pointer selects it.
//          Contents are deliberately not reset.
// Ports  :
//   clk    in  1       clock, rising edge
//   we     in  1       write enable
//   waddr  in  ADDR_W  write address
//   wdata  in  DATA_W  write data
//   raddr  in  ADDR_W  read address
//   rdata  out DATA_W  read data (combinational)
module lifo_stack_param_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Module : lifo_stack_param
// Purpose: Parametrised LIFO stack for the MEM-stage PUSH/POP path.
//          Supports replace-top (push+pop together), synchronous flush,
//          an almost-full threshold and sticky overflow/underflow flags.
//          The top entry is visible combinationally on Data_out so a pop
//          receives its data in the same cycle.
// Ports  :
//   CLK          in  1       clock, rising edge
//   RST          in  1       asynchronous reset, active low
//   PUSH         in  1       push Data_in this cycle
//   POP          in  1       pop top entry this cycle
//   FLUSH        in  1       synchronous empty, overrides PUSH/POP
//   CLR_ERR      in  1       synchronous clear of OVF/UNF
//   Data_in      in  DATA_W  word to push / replace top
//   Data_out     out DATA_W  top-of-stack, 0 when empty
//   SP           out SP_W    occupancy (index of next free slot)
//   FULL         out 1       SP == DEPTH
//   EMPTY        out 1       SP == 0
//   ALMOST_FULL  out 1       SP >= AF_LEVEL
//   OVF          out 1       sticky: push while full without pop
//   UNF          out 1       sticky: pop while empty
module lifo_stack_param
  import lifo_stack_param_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int SP_W     = stackClog2(DEPTH + 1),
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              FLUSH,
  input  logic              CLR_ERR,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic [SP_W-1:0]   SP,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              OVF,
  output logic              UNF
);

  localparam int ADDR_W = stackClog2(DEPTH);
  // Shallow stacks would give a negative default threshold; clamp to 0.
  localparam int AF_CLAMPED = (AF_LEVEL < 0) ? 0 : AF_LEVEL;

  logic [SP_W-1:0]   spReg, spNext;
  logic              ovfReg, unfReg;
  logic              ovfSet, unfSet;
  logic              isEmpty, isFull;
  stackOp_e          op;

  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] topAddr;
  logic [ADDR_W-1:0] freeAddr;
  logic [DATA_W-1:0] topData;

  assign isEmpty  = (spReg == '0);
  assign isFull   = (spReg == SP_W'(DEPTH));
  // spReg - 1 wraps when empty, but the read is masked and no write uses
  // it in that case, so the wrapped value is harmless.
  assign topAddr  = ADDR_W'(spReg - SP_W'(1));
  assign freeAddr = ADDR_W'(spReg);

  // Priority decode: flush, then push+pop, then push, then pop.
  always_comb begin
    op = OP_IDLE;
    if (FLUSH) begin
      op = OP_FLUSH;
    end else if (PUSH && POP) begin
      op = isEmpty ? OP_PUSH_ON_EMPTY : OP_REPLACE;
    end else if (PUSH) begin
      op = isFull ? OP_OVERFLOW : OP_PUSH;
    end else if (POP) begin
      op = isEmpty ? OP_UNDERFLOW : OP_POP;
    end
  end

  always_comb begin
    spNext = spReg;
    wrEn   = 1'b0;
    wrAddr = freeAddr;
    ovfSet = 1'b0;
    unfSet = 1'b0;
    case (op)
      OP_FLUSH: begin
        spNext = '0;
      end
      OP_REPLACE: begin
        wrEn   = 1'b1;
        wrAddr = topAddr;
      end
      OP_PUSH_ON_EMPTY: begin
        wrEn   = 1'b1;
        wrAddr = '0;
        spNext = SP_W'(1);
        unfSet = 1'b1;
      end
      OP_PUSH: begin
        wrEn   = 1'b1;
        wrAddr = freeAddr;
        spNext = spReg + SP_W'(1);
      end
      OP_OVERFLOW: begin
        ovfSet = 1'b1;
      end
      OP_POP: begin
        spNext = spReg - SP_W'(1);
      end
      OP_UNDERFLOW: begin
        unfSet = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      spReg  <= '0;
      ovfReg <= 1'b0;
      unfReg <= 1'b0;
    end else begin
      spReg <= spNext;
      // A new error event in the same cycle as CLR_ERR keeps the flag set.
      if (ovfSet) begin
        ovfReg <= 1'b1;
      end else if (CLR_ERR) begin
        ovfReg <= 1'b0;
      end
      if (unfSet) begin
        unfReg <= 1'b1;
      end else if (CLR_ERR) begin
        unfReg <= 1'b0;
      end
    end
  end

  lifo_stack_param_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uRegfile (
    .clk   (CLK),
    .we    (wrEn),
    .waddr (wrAddr),
    .wdata (Data_in),
    .raddr (topAddr),
    .rdata (topData)
  );

  // Storage is not reset, so the empty case must be forced to zero.
  assign Data_out    = isEmpty ? '0 : topData;
  assign SP          = spReg;
  assign EMPTY       = isEmpty;
  assign FULL        = isFull;
  assign ALMOST_FULL = (spReg >= SP_W'(AF_CLAMPED));
  assign OVF         = ovfReg;
  assign UNF         = unfReg;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Testbench: tb_lifo_stack_param
// Directed sequence against a small reference stack model. Pops push their
// expected word into a scoreboard queue when driven; the word is popped and
// compared with Data_out before the edge (zero-latency read).
module tb_lifo_stack_param;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int SP_W     = 4;
  localparam int AF_LEVEL = DEPTH - 4;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic              push = 1'b0, pop = 1'b0, flush = 1'b0, clrErr = 1'b0;
  logic [DATA_W-1:0] dataIn = '0;
  logic [DATA_W-1:0] dataOut;
  logic [SP_W-1:0]   sp;
  logic              full, empty, almostFull, ovf, unf;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [DATA_W-1:0] mdl[$];
  logic              mdlOvf = 1'b0, mdlUnf = 1'b0;
  logic [DATA_W-1:0] scb[$];

  always #5 clk = ~clk;

  lifo_stack_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SP_W     (SP_W),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .CLK         (clk),
    .RST         (rstN),
    .PUSH        (push),
    .POP         (pop),
    .FLUSH       (flush),
    .CLR_ERR     (clrErr),
    .Data_in     (dataIn),
    .Data_out    (dataOut),
    .SP          (sp),
    .FULL        (full),
    .EMPTY       (empty),
    .ALMOST_FULL (almostFull),
    .OVF         (ovf),
    .UNF         (unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string name);
    int n;
    n = mdl.size();
    check({name, ".sp"},    32'(sp),         32'(n));
    check({name, ".empty"}, 32'(empty),      32'(n == 0));
    check({name, ".full"},  32'(full),       32'(n == DEPTH));
    check({name, ".af"},    32'(almostFull), 32'(n >= AF_LEVEL));
    check({name, ".ovf"},   32'(ovf),        32'(mdlOvf));
    check({name, ".unf"},   32'(unf),        32'(mdlUnf));
    check({name, ".dout"},  32'(dataOut),    (n == 0) ? 32'h0 : 32'(mdl[n-1]));
  endtask

  // One clocked transaction: drive, check zero-latency pop data, update
  // the model on the edge, then check all outputs.
  task automatic step(input string name, input logic pu, input logic po,
                      input logic fl, input logic ce, input logic [DATA_W-1:0] d);
    logic ovfEv, unfEv;
    @(negedge clk);
    push = pu; pop = po; flush = fl; clrErr = ce; dataIn = d;
    if (po && !pu && !fl && mdl.size() > 0) scb.push_back(mdl[$]);
    #1;
    if (po && !pu && !fl && scb.size() > 0) check({name, ".popdata"}, 32'(dataOut), 32'(scb.pop_front()));
    @(posedge clk);
    ovfEv = 1'b0; unfEv = 1'b0;
    if (fl) mdl.delete();
    else if (pu && po) begin
      if (mdl.size() > 0) mdl[mdl.size()-1] = d;
      else begin mdl.push_back(d); unfEv = 1'b1; end
    end else if (pu) begin
      if (mdl.size() < DEPTH) mdl.push_back(d);
      else ovfEv = 1'b1;
    end else if (po) begin
      if (mdl.size() > 0) void'(mdl.pop_back());
      else unfEv = 1'b1;
    end
    mdlOvf = ovfEv ? 1'b1 : (ce ? 1'b0 : mdlOvf);
    mdlUnf = unfEv ? 1'b1 : (ce ? 1'b0 : mdlUnf);
    #1;
    checkAll(name);
    $display("step %-10s push=%0b pop=%0b flush=%0b clr=%0b din=%h -> sp=%0d dout=%h full=%0b af=%0b ovf=%0b unf=%0b",
             name, pu, po, fl, ce, d, sp, dataOut, full, almostFull, ovf, unf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset, including a reset asserted in the middle of a push.
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    step("push1", 1, 0, 0, 0, 16'h0101);
    step("push2", 1, 0, 0, 0, 16'h0202);
    @(negedge clk);
    push = 1'b1; dataIn = 16'h0303;
    #2 rstN = 1'b0;
    #1;
    mdl.delete(); mdlOvf = 1'b0; mdlUnf = 1'b0;
    checkAll("reset");
    $display("step reset      async reset mid-push -> sp=%0d empty=%0b dout=%h", sp, empty, dataOut);
    @(negedge clk);
    push = 1'b0;
    rstN = 1'b1;

    // 2. Push/pop order.
    step("p11", 1, 0, 0, 0, 16'h0011);
    step("p22", 1, 0, 0, 0, 16'h0022);
    step("p33", 1, 0, 0, 0, 16'h0033);
    for (int i = 0; i < 3; i++) step("pop", 0, 1, 0, 0, 16'h0);

    // 3. Fill, almost-full threshold, overflow.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, 0, 16'(16'h1000 + i));
    step("ovfpush", 1, 0, 0, 0, 16'hDEAD);
    step("ovfhold", 0, 0, 0, 0, 16'h0);

    // 4. Drain, then underflow and clear behaviour.
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 0, 16'h0);
    step("clr", 0, 0, 0, 1, 16'h0);
    step("unfpop", 0, 1, 0, 0, 16'h0);
    step("clr", 0, 0, 0, 1, 16'h0);
    step("clr+unf", 0, 1, 0, 1, 16'h0);
    step("clr", 0, 0, 0, 1, 16'h0);

    // 5. Replace-top, at SP=2 and at FULL, then on empty.
    step("p55", 1, 0, 0, 0, 16'h0055);
    step("pAA", 1, 0, 0, 0, 16'h00AA);
    step("replBB", 1, 1, 0, 0, 16'h00BB);
    for (int i = 0; i < DEPTH - 2; i++) step("fill", 1, 0, 0, 0, 16'(16'h2000 + i));
    step("replfull", 1, 1, 0, 0, 16'h00CD);
    step("flush", 0, 0, 1, 0, 16'h0);
    step("replempty", 1, 1, 0, 0, 16'h00CC);

    // 6. Flush with PUSH asserted, then a fresh push.
    step("clr", 0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 0, 16'(16'h3000 + i));
    step("flushpush", 1, 0, 1, 0, 16'h0099);
    step("p77", 1, 0, 0, 0, 16'h0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
